// File: rtl/rr_sel_pkg.sv
// Shared definitions for the 4-lane round-robin selector.
// Holds the FSM state type, the lane count and select width,
// and a helper that turns a lane index into a one-hot grant.
package rr_sel_pkg;

    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a lane index
    function automatic logic [N-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority picker: finds the first requesting lane at or after ptr.
// Ports:
//   req   [3:0] in  per-lane request
//   ptr   [1:0] in  lane with highest priority
//   found       out some lane is requesting
//   idx   [1:0] out winning lane (equals ptr when nothing is found)
module rr_pick4
    import rr_sel_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] lane_c;

    // Scan ptr, ptr+1, ... with mod-4 wrap; first hit wins
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        lane_c = ptr;
        for (int i = 0; i < int'(N); i++) begin
            lane_c = ptr + SEL_W'(i);
            if (!found && req[lane_c]) begin
                found = 1'b1;
                idx   = lane_c;
            end
        end
    end

endmodule

// File: rtl/rr_sel4.sv
// 4-lane round-robin arbiter with bounded bursts. Presents the chosen lane
// as a registered select and one-hot grant, held until ready.
// Ports:
//   clk          in  rising-edge clock
//   rst          in  synchronous active-high reset
//   req   [3:0]  in  per-lane request
//   ready        in  consumer accepts current selection
//   s     [1:0]  out registered select index
//   gnt   [3:0]  out registered one-hot grant (zero when not valid)
//   valid        out registered, s/gnt meaningful
module rr_sel4
    import rr_sel_pkg::*;
#(
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             ready,
    output logic [SEL_W-1:0] s,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] burst_cnt;

    logic             xfer_c;
    logic             burst_more_c;
    logic [CNT_W:0]   cnt_next_c;
    logic [SEL_W-1:0] pick_ptr_c;
    logic             found_c;
    logic [SEL_W-1:0] idx_c;

    assign xfer_c = valid && ready;

    // Extra bit keeps burst_cnt+1 from wrapping when BURST fills CNT_W
    assign cnt_next_c   = (CNT_W+1)'(burst_cnt) + (CNT_W+1)'(1);
    assign burst_more_c = (cnt_next_c < (CNT_W+1)'(BURST)) && req[s];

    // While granting, the only pick that matters is at burst end, from s+1
    assign pick_ptr_c = (state == GRANT) ? s + SEL_W'(1) : ptr;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr_c),
        .found (found_c),
        .idx   (idx_c)
    );

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            s         <= '0;
            gnt       <= '0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        state     <= GRANT;
                        s         <= idx_c;
                        gnt       <= onehot4(idx_c);
                        valid     <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer_c) begin
                        if (burst_more_c) begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end else begin
                            ptr <= s + SEL_W'(1);
                            if (found_c) begin
                                s         <= idx_c;
                                gnt       <= onehot4(idx_c);
                                burst_cnt <= '0;
                            end else begin
                                // s keeps its last value on the way to idle
                                state <= IDLE;
                                valid <= 1'b0;
                                gnt   <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel4.sv
// Directed bench for rr_sel4: one instance with BURST=4, one with BURST=1.
module tb_rr_sel4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // BURST=4 instance
    logic       rst4, rdy4, v4;
    logic [3:0] req4, gnt4;
    logic [1:0] s4;

    // BURST=1 instance
    logic       rst1, rdy1, v1;
    logic [3:0] req1, gnt1;
    logic [1:0] s1;

    int checks = 0;
    int errors = 0;

    rr_sel4 #(.BURST(4), .CNT_W(3)) u_b4 (
        .clk   (clk),
        .rst   (rst4),
        .req   (req4),
        .ready (rdy4),
        .s     (s4),
        .gnt   (gnt4),
        .valid (v4)
    );

    rr_sel4 #(.BURST(1), .CNT_W(3)) u_b1 (
        .clk   (clk),
        .rst   (rst1),
        .req   (req1),
        .ready (rdy1),
        .s     (s1),
        .gnt   (gnt1),
        .valid (v1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Compare s, gnt, valid against expected select/valid; gnt derived here
    task automatic chk_out(input string tag,
                           input logic [1:0] gs, input logic [3:0] gg, input logic gv,
                           input logic [1:0] es, input logic ev);
        logic [3:0] eg;
        logic [3:0] one;
        one = 4'b0001;
        eg  = ev ? (one << es) : 4'b0000;
        check({tag, ".s"},     8'(gs), 8'(es));
        check({tag, ".gnt"},   8'(gg), 8'(eg));
        check({tag, ".valid"}, 8'(gv), 8'(ev));
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b1; req4 = 4'b0000; rdy4 = 1'b0;
        rst1 = 1'b1; req1 = 4'b0000; rdy1 = 1'b0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("b4_rst", s4, gnt4, v4, 2'd0, 1'b0);
        end
        rst4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("b4_idle", s4, gnt4, v4, 2'd0, 1'b0);
        end

        // Single lane burst: grant after one cycle, 4 transfers, regrant lane 2
        req4 = 4'b0100; rdy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("b4_single", s4, gnt4, v4, 2'd2, 1'b1);
        end
        // Burst bound: lane 1 joins, lane 2 finishes its second burst first
        req4 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("b4_burst_hold", s4, gnt4, v4, 2'd2, 1'b1);
        end
        tick();
        chk_out("b4_burst_rot", s4, gnt4, v4, 2'd1, 1'b1);
        // Requester drops: burst ends early, idle with s kept
        req4 = 4'b0000;
        tick();
        chk_out("b4_to_idle", s4, gnt4, v4, 2'd1, 1'b0);

        // Reset mid-burst on lane 1 after two transfers (ptr now 2)
        req4 = 4'b0010;
        tick();
        chk_out("b4_mid_g", s4, gnt4, v4, 2'd1, 1'b1);
        tick();
        tick();
        chk_out("b4_mid_x2", s4, gnt4, v4, 2'd1, 1'b1);
        rst4 = 1'b1;
        tick();
        chk_out("b4_mid_rst", s4, gnt4, v4, 2'd0, 1'b0);
        rst4 = 1'b0; req4 = 4'b0110;
        tick();
        chk_out("b4_post_rst", s4, gnt4, v4, 2'd1, 1'b1);

        // Backpressure hold with lane 0 dropping its request
        rst4 = 1'b1;
        tick();
        chk_out("b4_rst2", s4, gnt4, v4, 2'd0, 1'b0);
        rst4 = 1'b0; req4 = 4'b0011; rdy4 = 1'b0;
        tick();
        chk_out("b4_bp_g", s4, gnt4, v4, 2'd0, 1'b1);
        req4 = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out("b4_bp_hold", s4, gnt4, v4, 2'd0, 1'b1);
        end
        rdy4 = 1'b1;
        tick();
        chk_out("b4_bp_rel", s4, gnt4, v4, 2'd1, 1'b1);
        req4 = 4'b0000; rdy4 = 1'b0;

        // Pure round-robin rotation, no bubbles
        tick();
        chk_out("b1_rst", s1, gnt1, v1, 2'd0, 1'b0);
        rst1 = 1'b0; req1 = 4'b1111; rdy1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("b1_rr", s1, gnt1, v1, 2'(i), 1'b1);
        end

        // Wrap-around and skip of idle lanes
        rst1 = 1'b1;
        tick();
        chk_out("b1_rst2", s1, gnt1, v1, 2'd0, 1'b0);
        rst1 = 1'b0; req1 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("b1_wrap", s1, gnt1, v1, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b1);
        end
        req1 = 4'b0000; rdy1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
